// File: rtl/p_mul_pkg.sv
// Shared palu definitions for the packed multiplier: pack-width encodings,
// lane widths, FSM states and the lane-boundary mask helpers.
package p_mul_pkg;

  localparam int unsigned PW_B32 = 0;
  localparam int unsigned PW_B16 = 1;
  localparam int unsigned PW_B8  = 2;
  localparam int unsigned PW_B4  = 3;
  localparam int unsigned PW_B2  = 4;

  localparam logic [4:0] PW_32 = 5'b00001;
  localparam logic [4:0] PW_16 = 5'b00010;
  localparam logic [4:0] PW_8  = 5'b00100;
  localparam logic [4:0] PW_4  = 5'b01000;
  localparam logic [4:0] PW_2  = 5'b10000;

  localparam logic [5:0] W_32 = 6'd32;
  localparam logic [5:0] W_16 = 6'd16;
  localparam logic [5:0] W_8  = 6'd8;
  localparam logic [5:0] W_4  = 6'd4;
  localparam logic [5:0] W_2  = 6'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic pw_legal(input logic [4:0] pw);
    case (pw)
      PW_32, PW_16, PW_8, PW_4, PW_2: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Iteration count minus one; illegal widths never enter RUN.
  function automatic logic [4:0] cnt_init(input logic [4:0] pw);
    case (pw)
      PW_32:   return 5'(W_32 - 6'd1);
      PW_16:   return 5'(W_16 - 6'd1);
      PW_8:    return 5'(W_8 - 6'd1);
      PW_4:    return 5'(W_4 - 6'd1);
      PW_2:    return 5'(W_2 - 6'd1);
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_lsb_mask(input logic [4:0] pw);
    case (pw)
      PW_32:   return 32'h0000_0001;
      PW_16:   return 32'h0001_0001;
      PW_8:    return 32'h0101_0101;
      PW_4:    return 32'h1111_1111;
      PW_2:    return 32'h5555_5555;
      default: return 32'h0000_0001;
    endcase
  endfunction

endpackage

// File: rtl/p_mul_if.sv
// Request/response bundle between the palu issue logic and the packed multiplier.
interface p_mul_if;
  logic        mul_valid;
  logic        mul_flush;
  logic [31:0] mul_lhs;
  logic [31:0] mul_rhs;
  logic [4:0]  mul_pw;
  logic        mul_high;
  logic        mul_ready;
  logic [31:0] mul_result;

  modport master (
    output mul_valid, mul_flush, mul_lhs, mul_rhs, mul_pw, mul_high,
    input  mul_ready, mul_result
  );

  modport slave (
    input  mul_valid, mul_flush, mul_lhs, mul_rhs, mul_pw, mul_high,
    output mul_ready, mul_result
  );
endinterface

// File: rtl/p_mul_addsub.sv
// Packed adder/subtractor p_addsub: ripple add with the carry chain cut at
// every lane LSB; c_out exposes the carry out of each bit position.
module p_addsub
  import p_mul_pkg::*;
(
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [4:0]  pw,
  input  logic        sub,
  output logic [31:0] result,
  output logic [31:0] c_out
);

  logic [31:0] lsb_mask;
  logic        carry;
  logic        b_bit;
  logic        c_in;

  always_comb begin
    lsb_mask = lane_lsb_mask(pw);
    result   = 32'h0000_0000;
    c_out    = 32'h0000_0000;
    carry    = 1'b0;
    b_bit    = 1'b0;
    c_in     = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b_bit     = rhs[i] ^ sub;
      c_in      = lsb_mask[i] ? sub : carry;
      result[i] = lhs[i] ^ b_bit ^ c_in;
      c_out[i]  = (lhs[i] & b_bit) | (lhs[i] & c_in) | (b_bit & c_in);
      carry     = c_out[i];
    end
  end

endmodule

// File: rtl/p_mul.sv
// Sequential packed unsigned multiplier: one shift-and-add step per cycle,
// each lane shifting {carry, acc, mplier} right independently.
module p_mul
  import p_mul_pkg::*;
(
  input  logic     g_clk,
  input  logic     g_reset,
  p_mul_if.slave   bus
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] lhs_q, lhs_d;
  logic [4:0]  pw_q, pw_d;
  logic        high_q, high_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mplier_q, mplier_d;

  logic [31:0] lsb_mask, msb_mask, addend, sum, carry_out;
  logic [31:0] acc_nx, mplier_nx;
  logic        rep_bit, sum_lsb;

  assign lsb_mask = lane_lsb_mask(pw_q);
  assign msb_mask = {lsb_mask[0], lsb_mask[31:1]};

  always_comb begin
    addend  = 32'h0000_0000;
    rep_bit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rep_bit   = lsb_mask[i] ? mplier_q[i] : rep_bit;
      addend[i] = lhs_q[i] & rep_bit;
    end
  end

  p_addsub u_addsub (
    .lhs    (acc_q),
    .rhs    (addend),
    .pw     (pw_q),
    .sub    (1'b0),
    .result (sum),
    .c_out  (carry_out)
  );

  // Lane MSB takes the lane carry (acc) and the sum's lane LSB (mplier).
  always_comb begin
    acc_nx    = 32'h0000_0000;
    mplier_nx = 32'h0000_0000;
    sum_lsb   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sum_lsb = lsb_mask[i] ? sum[i] : sum_lsb;
      if (msb_mask[i]) begin
        acc_nx[i]    = carry_out[i];
        mplier_nx[i] = sum_lsb;
      end else begin
        acc_nx[i]    = sum[(i + 1) % 32];
        mplier_nx[i] = mplier_q[(i + 1) % 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lhs_d    = lhs_q;
    pw_d     = pw_q;
    high_d   = high_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mul_valid && !bus.mul_flush) begin
          lhs_d  = bus.mul_lhs;
          pw_d   = bus.mul_pw;
          high_d = bus.mul_high;
          acc_d  = 32'h0000_0000;
          cnt_d  = cnt_init(bus.mul_pw);
          if (pw_legal(bus.mul_pw)) begin
            mplier_d = bus.mul_rhs;
            state_d  = ST_RUN;
          end else begin
            mplier_d = 32'h0000_0000;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d    = acc_nx;
        mplier_d = mplier_nx;
        cnt_d    = cnt_q - 5'd1;
        state_d  = (cnt_q == 5'd0) ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.mul_flush) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      lhs_q    <= 32'h0000_0000;
      pw_q     <= 5'd0;
      high_q   <= 1'b0;
      acc_q    <= 32'h0000_0000;
      mplier_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lhs_q    <= lhs_d;
      pw_q     <= pw_d;
      high_q   <= high_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  assign bus.mul_ready  = (state_q == ST_DONE);
  assign bus.mul_result = high_q ? acc_q : mplier_q;

endmodule
